// File: rtl/wb_arbiter_if.sv
// Result-bus bundle between the functional units, the writeback arbiter and WriteBack.
// The master side presents FU results and observes the slots; the slave side is the arbiter.
interface wb_arbiter_if #(
    parameter int unsigned N_SRC  = 4,
    parameter int unsigned N_PORT = 2,
    parameter int unsigned ROB_W  = 6,
    parameter int unsigned PREG_W = 7,
    parameter int unsigned XLEN   = 32
);
    logic [N_SRC-1:0]         src_valid;
    logic [N_SRC-1:0]         src_ready;
    logic [N_SRC*ROB_W-1:0]   src_robIdx;
    logic [N_SRC*PREG_W-1:0]  src_rd;
    logic [N_SRC*XLEN-1:0]    src_res;

    logic [N_PORT-1:0]        wb_en;
    logic [N_PORT-1:0]        wb_we;
    logic [N_PORT*ROB_W-1:0]  wb_robIdx;
    logic [N_PORT*PREG_W-1:0] wb_rd;
    logic [N_PORT*XLEN-1:0]   wb_res;

    modport master (
        output src_valid, src_robIdx, src_rd, src_res,
        input  src_ready,
        input  wb_en, wb_we, wb_robIdx, wb_rd, wb_res
    );

    modport slave (
        input  src_valid, src_robIdx, src_rd, src_res,
        output src_ready,
        output wb_en, wb_we, wb_robIdx, wb_rd, wb_res
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-FU result FIFOs feeding N_PORT registered writeback slots,
// granted round-robin over the FIFO heads.
module wb_arbiter #(
    parameter int unsigned N_SRC  = 4,
    parameter int unsigned N_PORT = 2,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ROB_W  = 6,
    parameter int unsigned PREG_W = 7,
    parameter int unsigned XLEN   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    wb_arbiter_if.slave bus
);
    localparam int unsigned SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ROB_W-1:0]  rob_idx;
        logic [PREG_W-1:0] rd;
        logic [XLEN-1:0]   res;
    } entry_t;

    entry_t            mem        [N_SRC][DEPTH];
    logic [PTR_W-1:0]  head       [N_SRC];
    logic [PTR_W-1:0]  tail       [N_SRC];
    logic [CNT_W-1:0]  count      [N_SRC];
    logic [CNT_W-1:0]  count_nxt  [N_SRC];
    entry_t            in_entry   [N_SRC];
    entry_t            head_entry [N_SRC];
    logic [N_SRC-1:0]  ready_q;
    logic [N_SRC-1:0]  accept;
    logic [N_SRC-1:0]  nonempty;
    logic [N_SRC-1:0]  grant;
    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  rr_nxt;

    logic [N_PORT-1:0] slot_vld;
    logic [SRC_W-1:0]  slot_src   [N_PORT];
    entry_t            slot_entry [N_PORT];
    entry_t            slot_q     [N_PORT];
    logic [N_PORT-1:0] en_q;
    logic [N_PORT-1:0] we_q;

    // Unpack source buses and decode FIFO status from registered state only.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            in_entry[i].rob_idx = bus.src_robIdx[i*ROB_W +: ROB_W];
            in_entry[i].rd      = bus.src_rd[i*PREG_W +: PREG_W];
            in_entry[i].res     = bus.src_res[i*XLEN +: XLEN];
            head_entry[i]       = mem[i][head[i]];
            nonempty[i]         = (count[i] != '0);
            accept[i]           = bus.src_valid[i] && ready_q[i];
        end
    end

    // Round-robin scan from rr_ptr; the first N_PORT non-empty heads take slots in scan order.
    always_comb begin : arb
        int unsigned      ngrant;
        int unsigned      pos;
        logic [SRC_W-1:0] idx;
        grant    = '0;
        slot_vld = '0;
        for (int p = 0; p < N_PORT; p++) begin
            slot_src[p] = '0;
        end
        rr_nxt = rr_ptr;
        ngrant = 0;
        pos    = 0;
        idx    = '0;
        for (int k = 0; k < N_SRC; k++) begin
            pos = 32'(rr_ptr) + 32'(k);
            if (pos >= N_SRC) begin
                pos = pos - N_SRC;
            end
            idx = SRC_W'(pos);
            if (nonempty[idx] && (ngrant < N_PORT)) begin
                grant[idx] = 1'b1;
                for (int p = 0; p < N_PORT; p++) begin
                    if (32'(p) == ngrant) begin
                        slot_vld[p] = 1'b1;
                        slot_src[p] = idx;
                    end
                end
                ngrant = ngrant + 1;
                rr_nxt = (pos == N_SRC - 1) ? '0 : SRC_W'(pos + 1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            count_nxt[i] = count[i] + CNT_W'(accept[i]) - CNT_W'(grant[i]);
        end
        for (int p = 0; p < N_PORT; p++) begin
            slot_entry[p] = head_entry[slot_src[p]];
        end
    end

    // Storage is not reset: validity is carried entirely by count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (accept[i]) begin
                mem[i][tail[i]] <= in_entry[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < N_SRC; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
            ready_q <= '1;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (accept[i]) begin
                    tail[i] <= tail[i] + PTR_W'(1);
                end
                if (grant[i]) begin
                    head[i] <= head[i] + PTR_W'(1);
                end
                count[i]   <= count_nxt[i];
                ready_q[i] <= (count_nxt[i] != CNT_W'(DEPTH));
            end
        end
    end

    // Flush keeps the scan position; only reset rewinds it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (!flush) begin
            rr_ptr <= rr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q <= '0;
            we_q <= '0;
            for (int p = 0; p < N_PORT; p++) begin
                slot_q[p] <= '0;
            end
        end else if (flush) begin
            en_q <= '0;
            we_q <= '0;
        end else begin
            for (int p = 0; p < N_PORT; p++) begin
                en_q[p] <= slot_vld[p];
                we_q[p] <= slot_vld[p] && (slot_entry[p].rd != '0);
                if (slot_vld[p]) begin
                    slot_q[p] <= slot_entry[p];
                end
            end
        end
    end

    assign bus.src_ready = ready_q;
    assign bus.wb_en     = en_q;
    assign bus.wb_we     = we_q;

    for (genvar p = 0; p < N_PORT; p++) begin : g_slot
        assign bus.wb_robIdx[p*ROB_W +: ROB_W] = slot_q[p].rob_idx;
        assign bus.wb_rd[p*PREG_W +: PREG_W]   = slot_q[p].rd;
        assign bus.wb_res[p*XLEN +: XLEN]      = slot_q[p].res;
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: latency, round-robin order,
// rd=0 write suppression, per-source ordering, backpressure, flush and reset.
module tb_wb_arbiter;
    localparam int unsigned N_SRC  = 4;
    localparam int unsigned N_PORT = 2;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned ROB_W  = 6;
    localparam int unsigned PREG_W = 7;
    localparam int unsigned XLEN   = 32;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   errors = 0;
    int   checks = 0;

    wb_arbiter_if #(.N_SRC(N_SRC), .N_PORT(N_PORT), .ROB_W(ROB_W),
                    .PREG_W(PREG_W), .XLEN(XLEN)) bus ();

    wb_arbiter #(.N_SRC(N_SRC), .N_PORT(N_PORT), .DEPTH(DEPTH), .ROB_W(ROB_W),
                 .PREG_W(PREG_W), .XLEN(XLEN)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input int rob, input int rd, input logic [XLEN-1:0] res);
        bus.src_robIdx[s*ROB_W +: ROB_W] = ROB_W'(rob);
        bus.src_rd[s*PREG_W +: PREG_W]   = PREG_W'(rd);
        bus.src_res[s*XLEN +: XLEN]      = res;
    endtask

    function automatic logic [ROB_W-1:0] slot_rob(input int p);
        return bus.wb_robIdx[p*ROB_W +: ROB_W];
    endfunction

    function automatic logic [PREG_W-1:0] slot_rd(input int p);
        return bus.wb_rd[p*PREG_W +: PREG_W];
    endfunction

    function automatic logic [XLEN-1:0] slot_res(input int p);
        return bus.wb_res[p*XLEN +: XLEN];
    endfunction

    task automatic do_reset();
        rst           = 1'b1;
        flush         = 1'b0;
        bus.src_valid = '0;
        bus.src_robIdx = '0;
        bus.src_rd    = '0;
        bus.src_res   = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        flush         = 1'b1;
        bus.src_valid = '1;
        bus.src_robIdx = '1;
        bus.src_rd    = '1;
        bus.src_res   = '1;
        tick();
        tick();
        checks++; if (bus.wb_en !== 2'b00) begin errors++; $display("FAIL reset_en: got %b want 00", bus.wb_en); end
        checks++; if (bus.wb_we !== 2'b00) begin errors++; $display("FAIL reset_we: got %b want 00", bus.wb_we); end
        checks++; if (bus.wb_robIdx !== '0) begin errors++; $display("FAIL reset_rob: got %h want 0", bus.wb_robIdx); end
        checks++; if (bus.wb_rd !== '0) begin errors++; $display("FAIL reset_rd: got %h want 0", bus.wb_rd); end
        checks++; if (bus.wb_res !== '0) begin errors++; $display("FAIL reset_res: got %h want 0", bus.wb_res); end
        checks++; if (bus.src_ready !== 4'b1111) begin errors++; $display("FAIL reset_ready: got %b want 1111", bus.src_ready); end
        rst           = 1'b0;
        flush         = 1'b0;
        bus.src_valid = '0;
        tick();
        tick();
        checks++; if (bus.wb_en !== 2'b00) begin errors++; $display("FAIL reset_idle_en: got %b want 00", bus.wb_en); end
        checks++; if (bus.src_ready !== 4'b1111) begin errors++; $display("FAIL reset_idle_ready: got %b want 1111", bus.src_ready); end
    endtask

    task automatic test_single();
        do_reset();
        set_src(2, 5, 9, 32'hDEAD_BEEF);
        bus.src_valid = 4'b0100;
        checks++; if (bus.src_ready !== 4'b1111) begin errors++; $display("FAIL single_ready0: got %b want 1111", bus.src_ready); end
        tick();
        bus.src_valid = '0;
        checks++; if (bus.wb_en !== 2'b00) begin errors++; $display("FAIL single_t1_en: got %b want 00", bus.wb_en); end
        checks++; if (bus.src_ready !== 4'b1111) begin errors++; $display("FAIL single_ready1: got %b want 1111", bus.src_ready); end
        tick();
        checks++; if (bus.wb_en !== 2'b01) begin errors++; $display("FAIL single_t2_en: got %b want 01", bus.wb_en); end
        checks++; if (bus.wb_we !== 2'b01) begin errors++; $display("FAIL single_t2_we: got %b want 01", bus.wb_we); end
        checks++; if (slot_rob(0) !== 6'd5) begin errors++; $display("FAIL single_rob: got %0d want 5", slot_rob(0)); end
        checks++; if (slot_rd(0) !== 7'd9) begin errors++; $display("FAIL single_rd: got %0d want 9", slot_rd(0)); end
        checks++; if (slot_res(0) !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_res: got %h want deadbeef", slot_res(0)); end
        checks++; if (bus.src_ready !== 4'b1111) begin errors++; $display("FAIL single_ready2: got %b want 1111", bus.src_ready); end
        tick();
        checks++; if (bus.wb_en !== 2'b00) begin errors++; $display("FAIL single_t3_en: got %b want 00", bus.wb_en); end
    endtask

    task automatic test_all_valid();
        int               seq [N_SRC];
        logic [N_SRC-1:0] rdy;
        int               k;
        int               base;
        int               eseq;
        logic [N_SRC-1:0] exp_rdy;
        do_reset();
        for (int s = 0; s < N_SRC; s++) seq[s] = 0;
        bus.src_valid = '1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            for (int s = 0; s < N_SRC; s++) begin
                set_src(s, s*16 + seq[s], s*16 + seq[s] + 1, 32'hA000_0000 + 32'(s*256 + seq[s]));
            end
            rdy = bus.src_ready;
            tick();
            for (int s = 0; s < N_SRC; s++) if (rdy[s]) seq[s]++;
            if (cyc == 0) begin
                checks++; if (bus.wb_en !== 2'b00) begin errors++; $display("FAIL rr_first_en: got %b want 00", bus.wb_en); end
                checks++; if (bus.src_ready !== 4'b1111) begin errors++; $display("FAIL rr_first_ready: got %b want 1111", bus.src_ready); end
            end else begin
                k       = cyc - 1;
                base    = (k % 2 == 1) ? 2 : 0;
                eseq    = k / 2;
                exp_rdy = (k % 2 == 1) ? 4'b1100 : 4'b0011;
                checks++; if (bus.wb_en !== 2'b11) begin errors++; $display("FAIL rr_en k=%0d: got %b want 11", k, bus.wb_en); end
                checks++; if (slot_rob(0) !== ROB_W'(base*16 + eseq)) begin errors++; $display("FAIL rr_slot0 k=%0d: got %0d want %0d", k, slot_rob(0), base*16 + eseq); end
                checks++; if (slot_rob(1) !== ROB_W'((base+1)*16 + eseq)) begin errors++; $display("FAIL rr_slot1 k=%0d: got %0d want %0d", k, slot_rob(1), (base+1)*16 + eseq); end
                checks++; if (slot_res(1) !== 32'hA000_0000 + 32'((base+1)*256 + eseq)) begin errors++; $display("FAIL rr_res1 k=%0d: got %h", k, slot_res(1)); end
                checks++; if (bus.src_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready k=%0d: got %b want %b", k, bus.src_ready, exp_rdy); end
            end
        end
        bus.src_valid = '0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_src(1, 3, 0, 32'h0000_0055);
        bus.src_valid = 4'b0010;
        tick();
        bus.src_valid = '0;
        tick();
        checks++; if (bus.wb_en !== 2'b01) begin errors++; $display("FAIL rd0_en: got %b want 01", bus.wb_en); end
        checks++; if (bus.wb_we !== 2'b00) begin errors++; $display("FAIL rd0_we: got %b want 00", bus.wb_we); end
        checks++; if (slot_res(0) !== 32'h55) begin errors++; $display("FAIL rd0_res: got %h want 55", slot_res(0)); end
        set_src(0, 1, 10, 32'd1);
        bus.src_valid = 4'b0001;
        tick();
        set_src(0, 2, 10, 32'd2);
        tick();
        checks++; if (bus.wb_en !== 2'b01 || slot_res(0) !== 32'd1) begin errors++; $display("FAIL b2b_1: en %b res %0d want 01/1", bus.wb_en, slot_res(0)); end
        checks++; if (bus.src_ready !== 4'b1111) begin errors++; $display("FAIL b2b_ready: got %b want 1111", bus.src_ready); end
        set_src(0, 3, 10, 32'd3);
        tick();
        checks++; if (bus.wb_en !== 2'b01 || slot_res(0) !== 32'd2) begin errors++; $display("FAIL b2b_2: en %b res %0d want 01/2", bus.wb_en, slot_res(0)); end
        bus.src_valid = '0;
        tick();
        checks++; if (bus.wb_en !== 2'b01 || slot_res(0) !== 32'd3 || slot_rob(0) !== 6'd3) begin errors++; $display("FAIL b2b_3: en %b res %0d want 01/3", bus.wb_en, slot_res(0)); end
        checks++; if (bus.wb_we !== 2'b01) begin errors++; $display("FAIL b2b_we: got %b want 01", bus.wb_we); end
        tick();
        checks++; if (bus.wb_en !== 2'b00) begin errors++; $display("FAIL b2b_idle: got %b want 00", bus.wb_en); end
    endtask

    task automatic test_flush();
        do_reset();
        set_src(0, 10, 11, 32'h100);
        set_src(1, 20, 21, 32'h200);
        set_src(2, 30, 31, 32'h300);
        set_src(3, 40, 41, 32'h400);
        bus.src_valid = 4'b1111;
        tick();
        set_src(0, 11, 11, 32'h101);
        set_src(3, 41, 41, 32'h401);
        bus.src_valid = 4'b1001;
        tick();
        checks++; if (bus.wb_en !== 2'b11 || slot_rob(0) !== 6'd10 || slot_rob(1) !== 6'd20) begin errors++; $display("FAIL flush_pre: en %b rob %0d/%0d want 11 10/20", bus.wb_en, slot_rob(0), slot_rob(1)); end
        checks++; if (bus.src_ready !== 4'b0111) begin errors++; $display("FAIL flush_full: got %b want 0111", bus.src_ready); end
        set_src(1, 21, 21, 32'h201);
        bus.src_valid = 4'b0010;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.src_valid = '0;
        checks++; if (bus.wb_en !== 2'b00) begin errors++; $display("FAIL flush_en: got %b want 00", bus.wb_en); end
        checks++; if (bus.src_ready !== 4'b1111) begin errors++; $display("FAIL flush_ready: got %b want 1111", bus.src_ready); end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (bus.wb_en !== 2'b00) begin errors++; $display("FAIL flush_leak c=%0d: en %b rob %0d", c, bus.wb_en, slot_rob(0)); end
        end
        set_src(0, 50, 50, 32'h500);
        set_src(2, 52, 52, 32'h502);
        set_src(3, 53, 53, 32'h503);
        bus.src_valid = 4'b1101;
        tick();
        bus.src_valid = '0;
        tick();
        checks++; if (bus.wb_en !== 2'b11 || slot_rob(0) !== 6'd52 || slot_rob(1) !== 6'd53) begin errors++; $display("FAIL flush_rr: en %b rob %0d/%0d want 11 52/53", bus.wb_en, slot_rob(0), slot_rob(1)); end
        tick();
        checks++; if (bus.wb_en !== 2'b01 || slot_rob(0) !== 6'd50) begin errors++; $display("FAIL flush_rr_tail: en %b rob %0d want 01 50", bus.wb_en, slot_rob(0)); end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_src(0, 1, 5, 32'hE0);
        set_src(1, 17, 5, 32'hF1);
        set_src(2, 33, 5, 32'hF2);
        set_src(3, 49, 5, 32'hF3);
        bus.src_valid = 4'b1111;
        tick();
        set_src(0, 2, 5, 32'hE1);
        bus.src_valid = 4'b0001;
        tick();
        checks++; if (bus.wb_en !== 2'b11 || slot_res(0) !== 32'hE0 || slot_res(1) !== 32'hF1) begin errors++; $display("FAIL bp_e2: en %b res %h/%h", bus.wb_en, slot_res(0), slot_res(1)); end
        set_src(0, 3, 5, 32'hE2);
        tick();
        checks++; if (bus.wb_en !== 2'b11 || slot_res(0) !== 32'hF2 || slot_res(1) !== 32'hF3) begin errors++; $display("FAIL bp_e3: en %b res %h/%h", bus.wb_en, slot_res(0), slot_res(1)); end
        checks++; if (bus.src_ready !== 4'b1110) begin errors++; $display("FAIL bp_full: got %b want 1110", bus.src_ready); end
        set_src(0, 4, 5, 32'hE3);
        tick();
        checks++; if (bus.wb_en !== 2'b01 || slot_res(0) !== 32'hE1) begin errors++; $display("FAIL bp_e4: en %b res %h want 01/e1", bus.wb_en, slot_res(0)); end
        checks++; if (bus.src_ready !== 4'b1111) begin errors++; $display("FAIL bp_rise: got %b want 1111", bus.src_ready); end
        tick();
        bus.src_valid = '0;
        checks++; if (bus.wb_en !== 2'b01 || slot_res(0) !== 32'hE2) begin errors++; $display("FAIL bp_e5: en %b res %h want 01/e2", bus.wb_en, slot_res(0)); end
        tick();
        checks++; if (bus.wb_en !== 2'b01 || slot_res(0) !== 32'hE3) begin errors++; $display("FAIL bp_e6: en %b res %h want 01/e3", bus.wb_en, slot_res(0)); end
        tick();
        checks++; if (bus.wb_en !== 2'b00) begin errors++; $display("FAIL bp_once: en %b res %h want 00", bus.wb_en, slot_res(0)); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int s = 0; s < N_SRC; s++) set_src(s, s*16, s*16 + 1, 32'(s));
        bus.src_valid = 4'b1111;
        tick();
        for (int s = 0; s < N_SRC; s++) set_src(s, s*16 + 1, s*16 + 2, 32'(s + 16));
        tick();
        checks++; if (bus.wb_en !== 2'b11) begin errors++; $display("FAIL rmid_pre: got %b want 11", bus.wb_en); end
        rst = 1'b1;
        bus.src_valid = '0;
        tick();
        rst = 1'b0;
        checks++; if (bus.wb_en !== 2'b00 || bus.wb_we !== 2'b00) begin errors++; $display("FAIL rmid_en: en %b we %b want 00/00", bus.wb_en, bus.wb_we); end
        checks++; if (bus.src_ready !== 4'b1111) begin errors++; $display("FAIL rmid_ready: got %b want 1111", bus.src_ready); end
        set_src(1, 60, 7, 32'h601);
        set_src(2, 61, 7, 32'h602);
        set_src(3, 62, 7, 32'h603);
        bus.src_valid = 4'b1110;
        tick();
        bus.src_valid = '0;
        checks++; if (bus.wb_en !== 2'b00) begin errors++; $display("FAIL rmid_stale: got %b want 00", bus.wb_en); end
        tick();
        checks++; if (bus.wb_en !== 2'b11 || slot_rob(0) !== 6'd60 || slot_rob(1) !== 6'd61) begin errors++; $display("FAIL rmid_rr: en %b rob %0d/%0d want 11 60/61", bus.wb_en, slot_rob(0), slot_rob(1)); end
        tick();
        checks++; if (bus.wb_en !== 2'b01 || slot_rob(0) !== 6'd62) begin errors++; $display("FAIL rmid_tail: en %b rob %0d want 01 62", bus.wb_en, slot_rob(0)); end
        tick();
        checks++; if (bus.wb_en !== 2'b00) begin errors++; $display("FAIL rmid_idle: got %b want 00", bus.wb_en); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_valid();
        test_back_to_back();
        test_flush();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
